reg_bank_seq: RTL



---
 rtl/reg_bank_seq_pkg.sv | 15 +
 rtl/reg_bank_seq_wr_arb.sv | 20 ++
 rtl/reg_bank_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/reg_bank_seq_pkg.sv
// reg_bank_seq_pkg: states, op classes, instruction field positions and timeout default for reg_bank_seq
package reg_bank_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;
  localparam int OP_LSB = 30;
  localparam int ALU_OP_LSB = 28;
  localparam int DEST_LSB = 24;
  localparam int SRC1_LSB = 20;
  localparam int SRC2_LSB = 16;
  localparam int IMM_LSB = 0;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/reg_bank_seq_wr_arb.sv
// reg_wr_arb: write-port mux/grant, sequencer WB (seq_wb/seq_dest/seq_data) beats ext_* requests, idle port drives zeros
module reg_wr_arb (
  input  logic        seq_wb,
  input  logic [3:0]  seq_dest,
  input  logic [31:0] seq_data,
  input  logic        ext_req,
  input  logic [3:0]  ext_dest,
  input  logic [31:0] ext_data,
  output logic        ext_gnt,
  output logic        wr_en,
  output logic [3:0]  wr_dest,
  output logic [31:0] wr_data
);
  always_comb begin
    ext_gnt = ext_req && !seq_wb;
    wr_en = seq_wb || ext_gnt;
    wr_dest = seq_wb ? seq_dest : (ext_gnt ? ext_dest : 4'h0);
    wr_data = seq_wb ? seq_data : (ext_gnt ? ext_data : 32'h0);
  end
endmodule

// File: rtl/reg_bank_seq.sv
// reg_bank_seq: single-issue 16x32 register-bank sequencer (instr/ALU handshake/write-back/ext load arbitration), optional ALU timeout via REG_BANK_SEQ_TIMEOUT_EN
module reg_bank_seq
  import reg_bank_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr_in,
  output logic [3:0]  source_1_sel,
  output logic [3:0]  source_2_sel,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic        wr_en,
  output logic [3:0]  wr_dest,
  output logic [31:0] wr_data,
  input  logic        ext_wr_req,
  input  logic [3:0]  ext_wr_dest,
  input  logic [31:0] ext_wr_data,
  output logic        ext_wr_gnt,
  output logic        busy,
  output logic        err_illegal,
  output logic        err_timeout
);
  state_t state, state_nx;
  logic [1:0] cls, op_q;
  logic [3:0] dest_q, src1_q, src2_q;
  logic [31:0] res_q;
  logic accept, first_q, ill_q, tmo;
  assign cls = instr_in[OP_LSB +: 2];
  assign instr_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign accept = instr_valid && instr_ready;
  assign source_1_sel = src1_q;
  assign source_2_sel = src2_q;
  assign alu_op = op_q;
  assign alu_start = state == S_EXEC && first_q;
  assign err_illegal = ill_q;
`ifdef REG_BANK_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic to_q;
  assign tmo = state == S_EXEC && !alu_done && cnt == CW'(TIMEOUT_CYC - 1);
  assign err_timeout = to_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      to_q <= 1'b0;
    end else begin
      cnt <= (state == S_EXEC) ? cnt + 1'b1 : '0;
      to_q <= tmo;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = (state == S_IDLE) ? (!accept || cls == OP_NOP || cls == OP_ILL ? S_IDLE : (cls == OP_ALU ? S_READ : S_WB)) :
               (state == S_READ) ? S_EXEC :
               (state == S_EXEC) ? (alu_done ? S_WB : (tmo ? S_IDLE : S_EXEC)) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      dest_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      res_q <= '0;
      first_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      first_q <= state == S_READ;
      ill_q <= accept && cls == OP_ILL;
      if (accept) begin
        op_q <= instr_in[ALU_OP_LSB +: 2];
        dest_q <= instr_in[DEST_LSB +: 4];
        src1_q <= instr_in[SRC1_LSB +: 4];
        src2_q <= instr_in[SRC2_LSB +: 4];
      end
      if (accept && cls == OP_LDI) res_q <= {16'h0, instr_in[IMM_LSB +: 16]};
      else if (state == S_EXEC && alu_done) res_q <= alu_result;
    end
  reg_wr_arb u_arb (
    .seq_wb  (state == S_WB),
    .seq_dest(dest_q),
    .seq_data(res_q),
    .ext_req (ext_wr_req),
    .ext_dest(ext_wr_dest),
    .ext_data(ext_wr_data),
    .ext_gnt (ext_wr_gnt),
    .wr_en   (wr_en),
    .wr_dest (wr_dest),
    .wr_data (wr_data)
  );
endmodule
